// File: rtl/ps2_defs.sv
// Shared PS/2 definitions: host-transmit state encoding, frame geometry and
// 7 MHz default timing constants (frame constants also used by the keyboard decoder).
package ps2_defs;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INHIBIT = 3'd1;
  localparam logic [2:0] ST_REQUEST = 3'd2;
  localparam logic [2:0] ST_DATA    = 3'd3;
  localparam logic [2:0] ST_PARITY  = 3'd4;
  localparam logic [2:0] ST_STOP    = 3'd5;
  localparam logic [2:0] ST_ACK     = 3'd6;
  localparam logic [2:0] ST_RELEASE = 3'd7;

  localparam int FRAME_EDGES       = 11;
  localparam int DATA_BITS         = 8;
  localparam int INHIBIT_CYCLES_7M = 700;
  localparam int TIMEOUT_CYCLES_7M = 105000;

  // Odd parity bit: 1 when the byte holds an even number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes one raw PS/2 line, majority-filters three samples and flags
// filtered 1->0 transitions.
module ps2_line_filter (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic [2:0] samp_q;
  logic       filt_q;
  logic       fall_q;
  logic       maj;

  assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

  // Everything resets to the idle (high) bus level so reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      samp_q <= 3'b111;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      samp_q <= {samp_q[1:0], sync_q[1]};
      filt_q <= maj;
      fall_q <= filt_q & ~maj;
    end
  end

  assign level_o = filt_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, clock out
// data/parity/stop on device clock falling edges, then check the device ACK.
module ps2_host_tx
  import ps2_defs::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_7M,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_7M
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int INH_W  = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TO_W   = (TO_RAW > 17) ? TO_RAW : 17;

  localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);

  logic             clk_lvl, clk_fall;
  logic             dat_lvl, dat_fall_unused;

  logic [2:0]       state_q, state_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [3:0]       edge_q, edge_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             drive_q, drive_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             in_wait;

  ps2_line_filter u_clk_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_i  (ps2clk_in),
    .level_o (clk_lvl),
    .fall_o  (clk_fall)
  );

  ps2_line_filter u_dat_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_i  (ps2data_in),
    .level_o (dat_lvl),
    .fall_o  (dat_fall_unused)
  );

  assign in_wait = (state_q != ST_IDLE) && (state_q != ST_INHIBIT);

  always_comb begin
    state_d = state_q;
    inh_d   = inh_q;
    to_d    = to_q;
    edge_d  = edge_q;
    shift_d = shift_q;
    par_d   = par_q;
    drive_d = drive_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (in_wait) to_d = clk_fall ? '0 : to_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          shift_d = tx_data;
          par_d   = odd_parity(tx_data);
          inh_d   = '0;
          state_d = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        inh_d = inh_q + 1'b1;
        if (inh_q == INH_LAST) begin
          to_d    = '0;
          edge_d  = '0;
          drive_d = 1'b1;
          state_d = ST_REQUEST;
        end
      end
      ST_REQUEST, ST_DATA: begin
        if (clk_fall) begin
          edge_d  = edge_q + 4'd1;
          drive_d = ~shift_q[0];
          shift_d = shift_q >> 1;
          if (state_q == ST_REQUEST) state_d = ST_DATA;
          else if (edge_q == LAST_DATA) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (clk_fall) begin
          edge_d  = edge_q + 4'd1;
          drive_d = ~par_q;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (clk_fall) begin
          edge_d  = edge_q + 4'd1;
          drive_d = 1'b0;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (clk_fall) begin
          edge_d = edge_q + 4'd1;
          if (!dat_lvl) begin
            state_d = ST_RELEASE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_RELEASE: begin
        if (clk_lvl && dat_lvl) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A stalled device abandons the transfer; this overrides any other outcome.
    if (in_wait && !clk_fall && (to_q == TO_LAST)) begin
      err_d   = 1'b1;
      done_d  = 1'b0;
      drive_d = 1'b0;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      inh_q   <= '0;
      to_q    <= '0;
      edge_q  <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      drive_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      inh_q   <= inh_d;
      to_q    <= to_d;
      edge_q  <= edge_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      drive_q <= drive_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Start bit goes out in the final inhibit cycle, ahead of the clock release.
  assign ps2clk_oe  = (state_q == ST_INHIBIT);
  assign ps2data_oe = (state_q == ST_INHIBIT) ? (inh_q == INH_LAST) : drive_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign error      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device on a wired-AND bus clocks
// frames out of the host and compares them with the byte/parity rules.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 3000;
  localparam int H   = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2clk_oe, ps2data_oe, busy, done, error;
  logic       bus_clk, bus_dat;

  int n_chk = 0;
  int n_fail = 0;

  int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int req_cyc = 0, err_cyc = 0;
  int inh_run = 0, inh_last = 0, inh_dat_pos = -1, inh_dat_n = 0;

  assign bus_clk = dev_clk & ~ps2clk_oe;
  assign bus_dat = dev_dat & ~ps2data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .ps2clk_in  (bus_clk),
    .ps2data_in (bus_dat),
    .ps2clk_oe  (ps2clk_oe),
    .ps2data_oe (ps2data_oe),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  // Passive observer of pulses, inhibit window and request entry time.
  always @(negedge clk) begin
    cyc++;
    if (done) done_cnt++;
    if (error) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (done && error) both_cnt++;
    if (ps2clk_oe) begin
      if (ps2data_oe) begin
        inh_dat_n++;
        inh_dat_pos = inh_run;
      end
      inh_run++;
    end else if (inh_run > 0) begin
      inh_last = inh_run;
      inh_run  = 0;
      if (ps2data_oe) req_cyc = cyc;
    end
  end

  task automatic pulse_start(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic wait_request(output bit ok);
    int k = 0;
    while (!(!ps2clk_oe && ps2data_oe) && k < INH + 50) begin
      @(negedge clk);
      k++;
    end
    ok = (k < INH + 50);
  endtask

  task automatic transfer(input logic [7:0] d, input bit ack, input int inject_edge,
                          input int rst_edge);
    int d0, e0, n0, k, ones;
    bit ok, aborted;
    logic [10:0] rx;
    logic [9:0]  expv;
    d0 = done_cnt; e0 = err_cnt; n0 = inh_dat_n;
    aborted = 1'b0;
    rx = '1;
    pulse_start(d);
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_after_start: got %0b expected 1", busy);
    end
    wait_request(ok);
    n_chk++;
    if (!ok) begin
      n_fail++; $display("FAIL request_wait: no request state within %0d cycles", INH + 50);
    end
    for (int i = 1; i <= 11; i++) begin
      if (i == 11 && ack) dev_dat = 1'b0;
      repeat (H/2) @(negedge clk);
      if (i == 1) rx[0] = bus_dat;
      dev_clk = 1'b0;
      repeat (H/2) @(negedge clk);
      if (i == rst_edge) begin
        n_chk++;
        if (ps2data_oe !== 1'b1) begin
          n_fail++; $display("FAIL pre_reset_drive: got %0b expected 1", ps2data_oe);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (ps2clk_oe !== 1'b0 || ps2data_oe !== 1'b0 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL async_release: got clk_oe=%0b data_oe=%0b busy=%0b expected 0 0 0",
                   ps2clk_oe, ps2data_oe, busy);
        end
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        aborted = 1'b1;
        break;
      end
      if (i == inject_edge) begin
        tx_data  = 8'h55;
        tx_start = 1'b1;
      end
      @(negedge clk);
      tx_start = 1'b0;
      repeat (H/2 - 1) @(negedge clk);
      if (i <= 10) rx[i] = bus_dat;
      dev_clk = 1'b1;
    end
    dev_dat = 1'b1;
    k = 0;
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_drop: busy still high after %0d cycles", k);
    end
    if (aborted) begin
      n_chk++;
      if (done_cnt != d0 || err_cnt != e0) begin
        n_fail++;
        $display("FAIL reset_no_pulse: got done=%0d error=%0d expected 0 0",
                 done_cnt - d0, err_cnt - e0);
      end
    end else begin
      ones = $countones(d);
      for (int j = 0; j < 8; j++) expv[j] = ((d >> j) & 8'h01) != 8'h00;
      expv[8] = (ones % 2 == 0);
      expv[9] = 1'b1;
      n_chk++;
      if (rx[0] !== 1'b0) begin
        n_fail++; $display("FAIL start_bit: got %0b expected 0", rx[0]);
      end
      n_chk++;
      if (rx[10:1] !== expv) begin
        n_fail++; $display("FAIL frame_%02h: got %03h expected %03h", d, rx[10:1], expv);
      end
      n_chk++;
      if (inh_last != INH) begin
        n_fail++; $display("FAIL inhibit_len: got %0d expected %0d", inh_last, INH);
      end
      n_chk++;
      if (inh_dat_n - n0 != 1 || inh_dat_pos != INH - 1) begin
        n_fail++;
        $display("FAIL inhibit_start_bit: got count=%0d pos=%0d expected 1 %0d",
                 inh_dat_n - n0, inh_dat_pos, INH - 1);
      end
      n_chk++;
      if (done_cnt - d0 != (ack ? 1 : 0) || err_cnt - e0 != (ack ? 0 : 1)) begin
        n_fail++;
        $display("FAIL outcome_%02h: got done=%0d error=%0d expected %0d %0d", d,
                 done_cnt - d0, err_cnt - e0, ack ? 1 : 0, ack ? 0 : 1);
      end
    end
    n_chk++;
    if (ps2clk_oe !== 1'b0 || ps2data_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL lines_released: got %0b %0b expected 0 0", ps2clk_oe, ps2data_oe);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if ({ps2clk_oe, ps2data_oe, busy, done, error} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %05b expected 00000",
               {ps2clk_oe, ps2data_oe, busy, done, error});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_chk++;
    if ({ps2clk_oe, ps2data_oe, busy, done, error} !== 5'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %05b expected 00000",
               {ps2clk_oe, ps2data_oe, busy, done, error});
    end
  endtask

  task automatic test_idle_edges();
    int d0 = done_cnt;
    int e0 = err_cnt;
    for (int i = 0; i < 4; i++) begin
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      repeat (H) @(negedge clk);
    end
    n_chk++;
    if (busy !== 1'b0 || ps2clk_oe !== 1'b0 || ps2data_oe !== 1'b0 ||
        done_cnt != d0 || err_cnt != e0) begin
      n_fail++;
      $display("FAIL idle_edges: got busy=%0b oe=%0b%0b pulses=%0d expected idle, 0 pulses",
               busy, ps2clk_oe, ps2data_oe, done_cnt - d0 + err_cnt - e0);
    end
  endtask

  task automatic test_timeout();
    int d0, e0, k;
    bit ok;
    d0 = done_cnt; e0 = err_cnt;
    pulse_start(8'hA3);
    wait_request(ok);
    n_chk++;
    if (!ok) begin
      n_fail++; $display("FAIL timeout_request: request state not reached");
    end
    k = 0;
    while (!error && k < TMO + 100) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    n_chk++;
    if (err_cnt - e0 != 1 || err_cyc - req_cyc != TMO) begin
      n_fail++;
      $display("FAIL timeout_delay: got errors=%0d delay=%0d expected 1 %0d",
               err_cnt - e0, err_cyc - req_cyc, TMO);
    end
    n_chk++;
    if (busy !== 1'b0 || ps2clk_oe !== 1'b0 || ps2data_oe !== 1'b0 || done_cnt != d0) begin
      n_fail++;
      $display("FAIL timeout_release: got busy=%0b oe=%0b%0b done=%0d expected 0 00 0",
               busy, ps2clk_oe, ps2data_oe, done_cnt - d0);
    end
  endtask

  task automatic test_led_cmd();    transfer(8'hED, 1'b1, 0, 0); endtask
  task automatic test_parity();     transfer(8'h01, 1'b1, 0, 0); transfer(8'hFF, 1'b1, 0, 0); endtask
  task automatic test_nack();       transfer(8'h3C, 1'b0, 0, 0); endtask
  task automatic test_ignore_start(); transfer(8'hE7, 1'b1, 3, 0); endtask
  task automatic test_reset_mid();  transfer(8'h00, 1'b1, 0, 5); transfer(8'hF4, 1'b1, 0, 0); endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) transfer(8'($urandom), 1'b1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_idle_edges();
    test_led_cmd();
    test_parity();
    test_random();
    test_timeout();
    test_nack();
    test_ignore_start();
    test_reset_mid();
    repeat (5) @(negedge clk);
    n_chk++;
    if (both_cnt != 0) begin
      n_fail++; $display("FAIL done_error_overlap: got %0d expected 0", both_cnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
